// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the mips_cpu_bus memory-access unit.
package mips_bus_pkg;

    typedef enum logic [1:0] {IDLE, FETCH, DATA} mem_if_state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} mem_size_t;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Size 3 is illegal; halves need even addresses, words need 4-byte alignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) ||
               (size == 2'(SZ_HALF) && off[0]) ||
               (size == 2'(SZ_WORD) && off != 2'b00);
    endfunction

endpackage

// File: rtl/mips_bus_lane_align.sv
// Little-endian lane steering: store byteenable/writedata and load extraction/extension.
module mips_bus_lane_align
    import mips_bus_pkg::*;
(
    input  logic [1:0]        st_size,
    input  logic [1:0]        st_offset,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [BE_W-1:0]   st_be_c,
    output logic [DATA_W-1:0] st_wdata_c,
    input  logic [1:0]        ld_size,
    input  logic [1:0]        ld_offset,
    input  logic              ld_signed,
    input  logic [DATA_W-1:0] ld_rdata,
    output logic [DATA_W-1:0] ld_data_c
);

    logic [DATA_W-1:0] shifted;

    // Store side: replicate narrow data so every candidate lane carries it.
    always_comb begin
        st_be_c    = 4'b1111;
        st_wdata_c = st_wdata;
        case (st_size)
            2'(SZ_BYTE): begin
                st_be_c    = 4'b0001 << st_offset;
                st_wdata_c = {4{st_wdata[7:0]}};
            end
            2'(SZ_HALF): begin
                st_be_c    = 4'b0011 << st_offset;
                st_wdata_c = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be_c    = 4'b1111;
                st_wdata_c = st_wdata;
            end
        endcase
    end

    // Load side: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        shifted   = ld_rdata >> {ld_offset, 3'b000};
        ld_data_c = ld_rdata;
        case (ld_size)
            2'(SZ_BYTE): ld_data_c = {{24{ld_signed & shifted[7]}}, shifted[7:0]};
            2'(SZ_HALF): ld_data_c = {{16{ld_signed & shifted[15]}}, shifted[15:0]};
            default:     ld_data_c = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mips_cpu_bus_mem_if.sv
// Memory-access unit: arbitrates fetch/data requests and runs one Avalon-style bus transfer at a time.
module mips_cpu_bus_mem_if
    import mips_bus_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [DATA_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_instr,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [1:0]        data_size,
    input  logic              data_signed,
    input  logic [DATA_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_err,
    output logic [DATA_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata
);

    localparam int unsigned CNT_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

    mem_if_state_t     state;
    logic              lat_we;
    logic              lat_signed;
    logic [1:0]        lat_size;
    logic [1:0]        lat_offset;
    logic [CNT_W-1:0]  wait_cnt;

    logic [BE_W-1:0]   st_be_c;
    logic [DATA_W-1:0] st_wdata_c;
    logic [DATA_W-1:0] ld_data_c;

    mips_bus_lane_align u_align (
        .st_size    (data_size),
        .st_offset  (data_addr[1:0]),
        .st_wdata   (data_wdata),
        .st_be_c    (st_be_c),
        .st_wdata_c (st_wdata_c),
        .ld_size    (lat_size),
        .ld_offset  (lat_offset),
        .ld_signed  (lat_signed),
        .ld_rdata   (readdata),
        .ld_data_c  (ld_data_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            read        <= 1'b0;
            write       <= 1'b0;
            address     <= '0;
            writedata   <= '0;
            byteenable  <= '0;
            fetch_valid <= 1'b0;
            fetch_instr <= '0;
            data_valid  <= 1'b0;
            data_rdata  <= '0;
            bus_err     <= 1'b0;
            lat_we      <= 1'b0;
            lat_signed  <= 1'b0;
            lat_size    <= 2'b00;
            lat_offset  <= 2'b00;
            wait_cnt    <= '0;
        end else begin
            fetch_valid <= 1'b0;
            data_valid  <= 1'b0;
            bus_err     <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    // Data has priority over fetch when both are pending.
                    if (data_req) begin
                        if (is_misaligned(data_size, data_addr[1:0])) begin
                            bus_err <= 1'b1;
                        end else begin
                            state      <= DATA;
                            address    <= {data_addr[DATA_W-1:2], 2'b00};
                            byteenable <= st_be_c;
                            writedata  <= data_we ? st_wdata_c : '0;
                            read       <= ~data_we;
                            write      <= data_we;
                            lat_we     <= data_we;
                            lat_signed <= data_signed;
                            lat_size   <= data_size;
                            lat_offset <= data_addr[1:0];
                        end
                    end else if (fetch_req) begin
                        if (fetch_addr[1:0] != 2'b00) begin
                            bus_err <= 1'b1;
                        end else begin
                            state      <= FETCH;
                            address    <= fetch_addr;
                            byteenable <= 4'b1111;
                            writedata  <= '0;
                            read       <= 1'b1;
                            write      <= 1'b0;
                        end
                    end
                end
                FETCH, DATA: begin
                    if (!waitrequest) begin
                        read     <= 1'b0;
                        write    <= 1'b0;
                        state    <= IDLE;
                        wait_cnt <= '0;
                        if (state == FETCH) begin
                            fetch_instr <= readdata;
                            fetch_valid <= 1'b1;
                        end else begin
                            data_rdata <= lat_we ? '0 : ld_data_c;
                            data_valid <= 1'b1;
                        end
                    end else if (WAIT_TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
                        // Slave stalled too long: abandon the transfer.
                        read     <= 1'b0;
                        write    <= 1'b0;
                        bus_err  <= 1'b1;
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_mem_if.sv
// Directed bench for mips_cpu_bus_mem_if with hand-computed expectations.
module tb_mips_cpu_bus_mem_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic        data_req;
    logic        data_we;
    logic [1:0]  data_size;
    logic        data_signed;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        bus_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int n_cmp = 0;
    int n_err = 0;

    mips_cpu_bus_mem_if #(.WAIT_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_size   (data_size),
        .data_signed (data_signed),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_valid  (data_valid),
        .data_rdata  (data_rdata),
        .bus_err     (bus_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        fetch_req   = 1'b0;
        fetch_addr  = 32'h0;
        data_req    = 1'b0;
        data_we     = 1'b0;
        data_size   = 2'd0;
        data_signed = 1'b0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        waitrequest = 1'b0;
        readdata    = 32'h0;
        #1;
        chk("rst_read",  {31'b0, read},  32'h0);
        chk("rst_write", {31'b0, write}, 32'h0);
        chk("rst_addr",  address, 32'h0);
        chk("rst_be",    {28'b0, byteenable}, 32'h0);
        chk("rst_instr", fetch_instr, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // 1: zero-wait fetch
        fetch_req  = 1'b1;
        fetch_addr = 32'hBFC00000;
        readdata   = 32'h2402000A;
        tick();
        chk("f1_read", {31'b0, read}, 32'h1);
        chk("f1_be",   {28'b0, byteenable}, 32'hF);
        chk("f1_addr", address, 32'hBFC00000);
        chk("f1_valid_early", {31'b0, fetch_valid}, 32'h0);
        tick();
        chk("f1_read_drop", {31'b0, read}, 32'h0);
        chk("f1_valid", {31'b0, fetch_valid}, 32'h1);
        chk("f1_instr", fetch_instr, 32'h2402000A);
        fetch_req = 1'b0;
        tick();
        chk("f1_valid_pulse", {31'b0, fetch_valid}, 32'h0);

        // 2: LB signed then LBU at lane 3
        data_req    = 1'b1;
        data_we     = 1'b0;
        data_size   = 2'd0;
        data_signed = 1'b1;
        data_addr   = 32'hBFC00013;
        readdata    = 32'h80FF1234;
        tick();
        chk("lb_read", {31'b0, read}, 32'h1);
        chk("lb_be",   {28'b0, byteenable}, 32'h8);
        chk("lb_addr", address, 32'hBFC00010);
        tick();
        chk("lb_valid", {31'b0, data_valid}, 32'h1);
        chk("lb_rdata", data_rdata, 32'hFFFFFF80);
        data_req = 1'b0;
        tick();
        data_req    = 1'b1;
        data_signed = 1'b0;
        tick();
        tick();
        chk("lbu_valid", {31'b0, data_valid}, 32'h1);
        chk("lbu_rdata", data_rdata, 32'h00000080);
        data_req = 1'b0;
        tick();

        // 3: SH with three wait cycles
        data_req    = 1'b1;
        data_we     = 1'b1;
        data_size   = 2'd1;
        data_addr   = 32'hBFC00022;
        data_wdata  = 32'h0000BEEF;
        waitrequest = 1'b1;
        tick();
        chk("sh_write", {31'b0, write}, 32'h1);
        chk("sh_read",  {31'b0, read},  32'h0);
        chk("sh_be",    {28'b0, byteenable}, 32'hC);
        chk("sh_wdata", writedata, 32'hBEEFBEEF);
        chk("sh_addr",  address, 32'hBFC00020);
        tick();
        chk("sh_hold1", {31'b0, write}, 32'h1);
        tick();
        chk("sh_hold2", {31'b0, write}, 32'h1);
        tick();
        chk("sh_hold3", {31'b0, write}, 32'h1);
        chk("sh_wdata_stable", writedata, 32'hBEEFBEEF);
        chk("sh_valid_early", {31'b0, data_valid}, 32'h0);
        waitrequest = 1'b0;
        tick();
        chk("sh_write_drop", {31'b0, write}, 32'h0);
        chk("sh_valid", {31'b0, data_valid}, 32'h1);
        chk("sh_rdata", data_rdata, 32'h0);
        data_req = 1'b0;
        data_we  = 1'b0;
        tick();

        // 4: misaligned word and illegal size
        data_req  = 1'b1;
        data_size = 2'd2;
        data_addr = 32'hBFC00006;
        tick();
        chk("lw_mis_err",  {31'b0, bus_err}, 32'h1);
        chk("lw_mis_read", {31'b0, read}, 32'h0);
        data_req = 1'b0;
        tick();
        chk("lw_mis_err_pulse", {31'b0, bus_err}, 32'h0);
        chk("lw_mis_read2", {31'b0, read}, 32'h0);
        data_req  = 1'b1;
        data_size = 2'd3;
        data_addr = 32'hBFC00004;
        tick();
        chk("sz3_err",  {31'b0, bus_err}, 32'h1);
        chk("sz3_read", {31'b0, read}, 32'h0);
        data_req = 1'b0;
        tick();

        // 5: simultaneous requests, data first
        fetch_req   = 1'b1;
        fetch_addr  = 32'hBFC00100;
        data_req    = 1'b1;
        data_size   = 2'd2;
        data_signed = 1'b0;
        data_addr   = 32'hBFC00200;
        readdata    = 32'h12345678;
        tick();
        chk("tie_addr_data", address, 32'hBFC00200);
        chk("tie_read1", {31'b0, read}, 32'h1);
        tick();
        chk("tie_dvalid", {31'b0, data_valid}, 32'h1);
        chk("tie_drdata", data_rdata, 32'h12345678);
        chk("tie_idle_gap", {31'b0, read}, 32'h0);
        data_req = 1'b0;
        readdata = 32'h3C1DBFC0;
        tick();
        chk("tie_addr_fetch", address, 32'hBFC00100);
        chk("tie_read2", {31'b0, read}, 32'h1);
        tick();
        chk("tie_fvalid", {31'b0, fetch_valid}, 32'h1);
        chk("tie_instr", fetch_instr, 32'h3C1DBFC0);
        fetch_req = 1'b0;
        tick();

        // 6a: waitrequest stuck high, timeout after 8 stalled cycles
        fetch_req   = 1'b1;
        fetch_addr  = 32'hBFC00300;
        waitrequest = 1'b1;
        tick();
        chk("to_read_start", {31'b0, read}, 32'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_read_hold", {31'b0, read}, 32'h1);
        end
        tick();
        chk("to_read_drop", {31'b0, read}, 32'h0);
        chk("to_err", {31'b0, bus_err}, 32'h1);
        chk("to_no_valid", {31'b0, fetch_valid}, 32'h0);
        fetch_req = 1'b0;
        tick();
        chk("to_err_pulse", {31'b0, bus_err}, 32'h0);

        // 6b: reset during a stalled read
        fetch_req = 1'b1;
        tick();
        chk("rmid_read", {31'b0, read}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("rmid_read_async", {31'b0, read}, 32'h0);
        fetch_req   = 1'b0;
        waitrequest = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk("rmid_no_valid", {31'b0, fetch_valid}, 32'h0);
        chk("rmid_instr_clr", fetch_instr, 32'h0);
        chk("rmid_read_idle", {31'b0, read}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
